mc_decode: RTL

MC_DECODE -- requirements
Module: mc_decode

---
 rtl/mc_decode_if.sv | 39 +++
 rtl/mc_decode.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mc_decode_if.sv
// mc_decode_if: instruction fields in, datapath controls out.
// master drives Op/Funct/Rd/Mul; slave (the decoder) drives controls.
interface mc_decode_if #(
  parameter int ALUCTRL_W = 3
);
  logic [1:0]           Op;
  logic [5:0]           Funct;
  logic [3:0]           Rd;
  logic                 Mul;
  logic [1:0]           FlagW;
  logic                 PCS;
  logic                 NextPC;
  logic                 RegW;
  logic                 MemW;
  logic                 IRWrite;
  logic                 AdrSrc;
  logic [1:0]           ResultSrc;
  logic [1:0]           ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic [1:0]           ImmSrc;
  logic [1:0]           RegSrc;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic                 Retire;
  logic                 Illegal;

  modport master (
    output Op, Funct, Rd, Mul,
    input  FlagW, PCS, NextPC, RegW, MemW, IRWrite, AdrSrc,
    input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc,
    input  ALUControl, Retire, Illegal
  );

  modport slave (
    input  Op, Funct, Rd, Mul,
    output FlagW, PCS, NextPC, RegW, MemW, IRWrite, AdrSrc,
    output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc,
    output ALUControl, Retire, Illegal
  );
endinterface

// File: rtl/mc_decode.sv
// mc_decode: multicycle control unit (Moore FSM + ALU decoder).
// Ports: clk, reset (sync, active high), bus (mc_decode_if.slave).
// MC_DECODE_MUL_EN enables the multi-cycle MULEX multiply state.
module mc_decode #(
  parameter int ALUCTRL_W  = 3,
  parameter int MUL_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  mc_decode_if.slave bus
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECR, EXECI,
`ifdef MC_DECODE_MUL_EN
    MULEX,
`endif
    ALUWB, BRANCH
  } state_t;

  state_t state;

  logic [3:0] cmd;
  logic       is_cmp;
  logic       mul_ill;

  assign cmd    = bus.Funct[4:1];
  assign is_cmp = (cmd[3:2] == 2'b10);

`ifdef MC_DECODE_MUL_EN
  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
  logic [3:0] cnt;
  assign mul_ill = 1'b0;
`else
  // Without a multiplier, a MUL is flagged and executed as a plain EXECR.
  assign mul_ill = (bus.Op == 2'b00) & ~bus.Funct[5] & bus.Mul;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
`ifdef MC_DECODE_MUL_EN
      cnt   <= '0;
`endif
    end else begin
      case (state)
        FETCH:  state <= DECODE;
        DECODE: begin
          unique case (bus.Op)
            2'b01: state <= MEMADR;
            2'b10: state <= BRANCH;
            2'b11: state <= FETCH;
            default: begin
              if (bus.Funct[5]) begin
                state <= EXECI;
`ifdef MC_DECODE_MUL_EN
              end else if (bus.Mul) begin
                state <= MULEX;
                cnt   <= MUL_LOAD;
`endif
              end else begin
                state <= EXECR;
              end
            end
          endcase
        end
        MEMADR: state <= bus.Funct[0] ? MEMRD : MEMWR;
        MEMRD:  state <= MEMWB;
        EXECR,
        EXECI:  state <= is_cmp ? FETCH : ALUWB;
`ifdef MC_DECODE_MUL_EN
        MULEX: begin
          if (cnt == 4'd0) state <= ALUWB;
          else             cnt   <= cnt - 4'd1;
        end
`endif
        default: state <= FETCH;
      endcase
    end
  end

  logic [2:0] dec_ctl;
  logic       dec_bad;

  always_comb begin
    dec_ctl = 3'b000;
    dec_bad = 1'b0;
    unique case (1'b1)
      (cmd == 4'b0100) || (cmd == 4'b1011): dec_ctl = 3'b000;
      (cmd == 4'b0010) || (cmd == 4'b1010): dec_ctl = 3'b001;
      (cmd == 4'b0000) || (cmd == 4'b1000): dec_ctl = 3'b010;
      (cmd == 4'b1100):                     dec_ctl = 3'b011;
      (cmd == 4'b0001) || (cmd == 4'b1001): dec_ctl = 3'b100;
      (cmd == 4'b1101):                     dec_ctl = 3'b101;
      default:                              dec_bad = 1'b1;
    endcase
  end

  logic       irw, npc, regw, memw, adr;
  logic       alu_op, branch, mul_op, ill, ret;
  logic [1:0] rs, sa, sb;
  logic [2:0] ctl;

  always_comb begin
    irw    = 1'b0;
    npc    = 1'b0;
    regw   = 1'b0;
    memw   = 1'b0;
    adr    = 1'b0;
    alu_op = 1'b0;
    branch = 1'b0;
    mul_op = 1'b0;
    ill    = 1'b0;
    ret    = 1'b0;
    rs     = 2'b00;
    sa     = 2'b00;
    sb     = 2'b00;
    if (!reset) begin
      case (state)
        FETCH: begin
          irw = 1'b1;
          npc = 1'b1;
          sa  = 2'b01;
          sb  = 2'b10;
          rs  = 2'b10;
        end
        DECODE: begin
          sa  = 2'b01;
          sb  = 2'b10;
          rs  = 2'b10;
          ill = (bus.Op == 2'b11) | mul_ill;
        end
        MEMADR: sb = 2'b01;
        MEMRD:  adr = 1'b1;
        MEMWB: begin
          rs   = 2'b01;
          regw = 1'b1;
          ret  = 1'b1;
        end
        MEMWR: begin
          adr  = 1'b1;
          memw = 1'b1;
          ret  = 1'b1;
        end
        EXECR: begin
          alu_op = 1'b1;
          ret    = is_cmp;
        end
        EXECI: begin
          sb     = 2'b01;
          alu_op = 1'b1;
          ret    = is_cmp;
        end
`ifdef MC_DECODE_MUL_EN
        MULEX: mul_op = 1'b1;
`endif
        ALUWB: begin
          regw = 1'b1;
          ret  = 1'b1;
        end
        BRANCH: begin
          sb     = 2'b01;
          rs     = 2'b10;
          branch = 1'b1;
          ret    = 1'b1;
        end
        default: ;
      endcase
    end
    ctl = 3'b000;
    if (mul_op)      ctl = 3'b110;
    else if (alu_op) ctl = dec_ctl;
    // EXEC states last one cycle, so this is a single pulse.
    ill = ill | (alu_op & dec_bad);
  end

  assign bus.IRWrite    = irw;
  assign bus.NextPC     = npc;
  assign bus.RegW       = regw;
  assign bus.MemW       = memw;
  assign bus.AdrSrc     = adr;
  assign bus.ResultSrc  = rs;
  assign bus.ALUSrcA    = sa;
  assign bus.ALUSrcB    = sb;
  assign bus.ALUControl = ALUCTRL_W'(ctl);
  assign bus.Retire     = ret;
  assign bus.Illegal    = ill;
  assign bus.FlagW[1]   = alu_op & bus.Funct[0];
  assign bus.FlagW[0]   = alu_op & bus.Funct[0] & (ctl[2:1] == 2'b00);
  assign bus.PCS        = branch | (regw & (bus.Rd == 4'hF));
  assign bus.ImmSrc     = reset ? 2'b00 : bus.Op;
  assign bus.RegSrc[0]  = ~reset & (bus.Op == 2'b10);
  assign bus.RegSrc[1]  = ~reset & (bus.Op == 2'b01) & ~bus.Funct[0];

endmodule
